button_event_fsm: RTL and testbench

Downstream consumer of the debounce stage. Takes the one-cycle debounced sample (`db_signal`) and its qualifying strobe (`count_finished`) and turns the stream of button samples into discrete user events:
- press
- release
- short click
- long press
- auto-repeat while held

Sits between the debouncer and the application logic (mode/counter control), so application logic never sees raw sample timing.

---
 rtl/button_event_fsm.sv | 150 +++++++++++++++
 tb/tb_button_event_fsm.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/button_event_fsm.sv
// Purpose: turns qualified debounced button samples into press/release/click/long/repeat events.
// Latency: one cycle from the edge sampling sample_valid=1 to the registered event outputs.
// Backpressure: none; every strobe is consumed, and back-to-back strobes each produce their own result.
module button_event_fsm #(
  parameter int LONG_SAMPLES   = 16,
  parameter int REPEAT_SAMPLES = 4,
  parameter int CNT_W          = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_valid,
  input  logic       db_signal,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       click_pulse,
  output logic       long_pulse,
  output logic       repeat_pulse,
  output logic       held,
  output logic [7:0] press_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LONG_C = CNT_W'(LONG_SAMPLES);
  localparam logic [CNT_W-1:0] REP_C  = CNT_W'(REPEAT_SAMPLES);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  logic [7:0]       press_count_q, press_count_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             click_q, click_d;
  logic             long_q, long_d;
  logic             repeat_q, repeat_d;
  logic             held_q, held_d;

  logic [CNT_W-1:0] hold_inc;
  logic [CNT_W-1:0] rep_inc;

  assign hold_inc = hold_cnt_q + ONE_C;
  assign rep_inc  = rep_cnt_q + ONE_C;

  // Next-state, counter and event decode; only qualified samples move anything.
  always_comb begin
    state_d       = state_q;
    hold_cnt_d    = hold_cnt_q;
    rep_cnt_d     = rep_cnt_q;
    press_count_d = press_count_q;
    press_d       = 1'b0;
    release_d     = 1'b0;
    click_d       = 1'b0;
    long_d        = 1'b0;
    repeat_d      = 1'b0;

    if (sample_valid) begin
      case (state_q)
        IDLE: begin
          if (db_signal) begin
            state_d       = PRESSED;
            hold_cnt_d    = ONE_C;
            press_d       = 1'b1;
            press_count_d = press_count_q + 8'd1;
          end
        end
        PRESSED: begin
          if (db_signal) begin
            // Long threshold is checked here only, so it can never coincide with a repeat.
            if (hold_inc == LONG_C) begin
              state_d   = HELD;
              long_d    = 1'b1;
              rep_cnt_d = '0;
            end else begin
              hold_cnt_d = hold_inc;
            end
          end else begin
            state_d    = IDLE;
            release_d  = 1'b1;
            click_d    = 1'b1;
            hold_cnt_d = '0;
          end
        end
        HELD: begin
          if (db_signal) begin
            if (rep_inc == REP_C) begin
              repeat_d  = 1'b1;
              rep_cnt_d = '0;
            end else begin
              rep_cnt_d = rep_inc;
            end
          end else begin
            state_d    = IDLE;
            release_d  = 1'b1;
            hold_cnt_d = '0;
            rep_cnt_d  = '0;
          end
        end
        default: begin
          state_d    = IDLE;
          hold_cnt_d = '0;
          rep_cnt_d  = '0;
        end
      endcase
    end

    // held tracks the registered state so it rises with long_pulse and falls with release.
    held_d = (state_d == HELD);
  end

  // State, counters and all outputs registered; synchronous reset drops any pending event.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      hold_cnt_q    <= '0;
      rep_cnt_q     <= '0;
      press_count_q <= '0;
      press_q       <= 1'b0;
      release_q     <= 1'b0;
      click_q       <= 1'b0;
      long_q        <= 1'b0;
      repeat_q      <= 1'b0;
      held_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      rep_cnt_q     <= rep_cnt_d;
      press_count_q <= press_count_d;
      press_q       <= press_d;
      release_q     <= release_d;
      click_q       <= click_d;
      long_q        <= long_d;
      repeat_q      <= repeat_d;
      held_q        <= held_d;
    end
  end

  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign click_pulse   = click_q;
  assign long_pulse    = long_q;
  assign repeat_pulse  = repeat_q;
  assign held          = held_q;
  assign press_count   = press_count_q;

endmodule

// File: tb/tb_button_event_fsm.sv
module tb_button_event_fsm;

  typedef struct packed {
    logic       press;
    logic       rel;
    logic       click;
    logic       lng;
    logic       rpt;
    logic       held;
    logic [7:0] cnt;
  } ev_t;

  logic       clk;
  logic       reset;
  logic       sample_valid;
  logic       db_signal;
  logic       press_pulse;
  logic       release_pulse;
  logic       click_pulse;
  logic       long_pulse;
  logic       repeat_pulse;
  logic       held;
  logic [7:0] press_count;

  int total = 0;
  int bad   = 0;
  ev_t exp_q[$];

  button_event_fsm #(
    .LONG_SAMPLES  (4),
    .REPEAT_SAMPLES(2),
    .CNT_W         (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .db_signal    (db_signal),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .click_pulse  (click_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse),
    .held         (held),
    .press_count  (press_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ev_t mk(input logic p, input logic r, input logic c,
                             input logic l, input logic rp, input logic h,
                             input logic [7:0] n);
    ev_t e;
    e.press = p; e.rel = r; e.click = c; e.lng = l; e.rpt = rp; e.held = h; e.cnt = n;
    return e;
  endfunction

  // Monitor: every cycle carrying any event output is matched against the scoreboard.
  always @(negedge clk) begin
    ev_t got;
    ev_t e;
    got = mk(press_pulse, release_pulse, click_pulse, long_pulse, repeat_pulse, held, press_count);
    if ((press_pulse | release_pulse | click_pulse | long_pulse | repeat_pulse) === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event got p%b r%b c%b l%b rp%b h%b cnt=%0d, required no event",
                 got.press, got.rel, got.click, got.lng, got.rpt, got.held, got.cnt);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          bad++;
          $display("FAIL event got p%b r%b c%b l%b rp%b h%b cnt=%0d required p%b r%b c%b l%b rp%b h%b cnt=%0d",
                   got.press, got.rel, got.click, got.lng, got.rpt, got.held, got.cnt,
                   e.press, e.rel, e.click, e.lng, e.rpt, e.held, e.cnt);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s got=%0h required=%0h", name, got, req);
    end
  endtask

  // One qualified sample; an expected event (if any) goes to the scoreboard first.
  task automatic strobe(input logic db, input logic has_ev, input ev_t e, input int gap);
    if (has_ev) exp_q.push_back(e);
    sample_valid = 1'b1;
    db_signal    = db;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    db_signal    = 1'b0;
    for (int i = 0; i < gap; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      sample_valid = 1'($urandom);
      db_signal    = 1'($urandom);
      @(posedge clk); #1;
    end
    sample_valid = 1'b0;
    db_signal    = 1'b0;
    reset        = 1'b1;
  endtask

  ev_t none;

  initial begin
    none         = '0;
    reset        = 1'b0;
    sample_valid = 1'b0;
    db_signal    = 1'b0;
    #1;
    do_reset(3);
    @(negedge clk);
    check("reset_press_count", {24'd0, press_count}, 32'd0);
    check("reset_held", {31'd0, held}, 32'd0);
    check("reset_pulses", {27'd0, press_pulse, release_pulse, click_pulse, long_pulse, repeat_pulse}, 32'd0);
    @(posedge clk); #1;

    // Short click 1,1,0 (back-to-back strobes on the first two).
    strobe(1'b1, 1'b1, mk(1,0,0,0,0,0,8'd1), 0);
    strobe(1'b1, 1'b0, none, 2);
    strobe(1'b0, 1'b1, mk(0,1,1,0,0,0,8'd1), 3);
    check("click_count", {24'd0, press_count}, 32'd1);

    // Long press: nine 1s then a 0.
    strobe(1'b1, 1'b1, mk(1,0,0,0,0,0,8'd2), 1);
    strobe(1'b1, 1'b0, none, 0);
    strobe(1'b1, 1'b0, none, 1);
    strobe(1'b1, 1'b1, mk(0,0,0,1,0,1,8'd2), 2);
    @(negedge clk);
    check("held_after_long", {31'd0, held}, 32'd1);
    @(posedge clk); #1;
    strobe(1'b1, 1'b0, none, 0);
    strobe(1'b1, 1'b1, mk(0,0,0,0,1,1,8'd2), 0);
    strobe(1'b1, 1'b0, none, 1);
    strobe(1'b1, 1'b1, mk(0,0,0,0,1,1,8'd2), 1);
    strobe(1'b1, 1'b0, none, 1);
    @(negedge clk);
    check("held_before_release", {31'd0, held}, 32'd1);
    @(posedge clk); #1;
    strobe(1'b0, 1'b1, mk(0,1,0,0,0,0,8'd2), 2);
    check("held_after_release", {31'd0, held}, 32'd0);

    // Ignored samples: level high, no strobe.
    db_signal = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
    end
    db_signal = 1'b0;
    check("ignored_held", {31'd0, held}, 32'd0);
    check("ignored_count", {24'd0, press_count}, 32'd2);

    // Reset while held: no release, counts cleared, next press is fresh.
    strobe(1'b1, 1'b1, mk(1,0,0,0,0,0,8'd3), 0);
    strobe(1'b1, 1'b0, none, 0);
    strobe(1'b1, 1'b0, none, 0);
    strobe(1'b1, 1'b1, mk(0,0,0,1,0,1,8'd3), 1);
    reset = 1'b0;
    sample_valid = 1'b1;
    db_signal = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    sample_valid = 1'b0;
    @(negedge clk);
    check("rst_hold_held", {31'd0, held}, 32'd0);
    check("rst_hold_count", {24'd0, press_count}, 32'd0);
    check("rst_hold_no_release", {31'd0, release_pulse}, 32'd0);
    @(posedge clk); #1;
    strobe(1'b1, 1'b1, mk(1,0,0,0,0,0,8'd1), 1);
    strobe(1'b0, 1'b1, mk(0,1,1,0,0,0,8'd1), 1);

    // Counter wrap: 256 clicks from a cleared count.
    do_reset(1);
    for (int i = 0; i < 256; i++) begin
      strobe(1'b1, 1'b1, mk(1,0,0,0,0,0,8'((i + 1) % 256)), i % 2);
      strobe(1'b0, 1'b1, mk(0,1,1,0,0,0,8'((i + 1) % 256)), 0);
    end
    @(posedge clk); #1;
    check("wrap_count", {24'd0, press_count}, 32'd0);

    // Drain: every expected event must have been seen.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
